// File: rtl/audio_buf.sv
// audio_buf: bus-programmable stereo sample FIFO feeding a DAC.
//
// A bus master writes left/right 20-bit samples (left into a staging
// register, right pushes the combined frame), programs enable, interrupt
// enable and a fill threshold, and reads back status. The DAC controller
// pulses `next` to take one frame; the frame appears on sample_l/sample_r
// after that edge and holds until the following pulse.
//
// Ports
//   clk, rst            single clock, synchronous active-high reset
//   stb, we, addr       bus strobe / write enable / register select
//   data_in, data_out   bus write / read data (read data valid while ack=1)
//   ack                 one-cycle registered access acknowledge
//   irq                 level interrupt: ien && count <= threshold
//   next                DAC frame request pulse
//   sample_l, sample_r  registered samples presented to the DAC
module audio_buf #(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stb,
   input  logic        we,
   input  logic [1:0]  addr,
   input  logic [31:0] data_in,
   output logic [31:0] data_out,
   output logic        ack,
   output logic        irq,
   input  logic        next,
   output logic [19:0] sample_l,
   output logic [19:0] sample_r
);

   localparam int DEPTH = 2 ** DEPTH_LOG2;
   localparam int CW    = DEPTH_LOG2 + 1;
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;
   localparam logic [CW-1:0]         CNT_ONE = 1;
   localparam logic [CW-1:0]         CNT_MAX = CW'(DEPTH);
   localparam logic [CW-1:0]         THR_RST = CW'(DEPTH / 2);

   logic                  ack_q, ack_d;
   logic [31:0]           dout_q, dout_d;
   logic [19:0]           stage_q, stage_d;
   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d, thr_q, thr_d;
   logic [39:0]           out_q, out_d;
   logic                  en_q, en_d, ien_q, ien_d, und_q, und_d, ovr_q, ovr_d;
   logic [39:0]           mem_q [DEPTH];

   logic        wr_acc, push, push_ok, pop, pop_ok, full, empty;
   logic [39:0] frame, head;

   always_comb begin
      // A write commits at the edge that closes the ack cycle.
      wr_acc  = stb && we && ack_q;
      push    = wr_acc && (addr == 2'd1);
      full    = (count_q == CNT_MAX);
      empty   = (count_q == '0);
      push_ok = push && !full;
      pop     = next && en_q;
      pop_ok  = pop && !empty;
      frame   = {stage_q, data_in[19:0]};
      head    = mem_q[rd_ptr_q];

      ack_d    = stb && !ack_q;
      dout_d   = '0;
      stage_d  = stage_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      thr_d    = thr_q;
      out_d    = out_q;
      en_d     = en_q;
      ien_d    = ien_q;
      und_d    = und_q;
      ovr_d    = ovr_q;

      // Read data is captured alongside the rising ack.
      if (stb && !we && !ack_q) begin
         case (addr)
            2'd0:    dout_d = {12'b0, stage_q};
            2'd2:    dout_d = {16'b0, 8'(count_q), 2'b0, full, empty,
                               ovr_q, und_q, ien_q, en_q};
            2'd3:    dout_d = 32'(thr_q);
            default: dout_d = '0;
         endcase
      end

      if (wr_acc && addr == 2'd0) stage_d = data_in[19:0];
      if (wr_acc && addr == 2'd3) thr_d = data_in[CW-1:0];
      if (wr_acc && addr == 2'd2) begin
         en_d  = data_in[0];
         ien_d = data_in[1];
         if (data_in[2]) und_d = 1'b0;
         if (data_in[3]) ovr_d = 1'b0;
      end

      // Sticky sets come after the clears so a same-edge set wins.
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (push && full) ovr_d = 1'b1;

      if (next) out_d = pop_ok ? head : '0;
      if (pop && empty) und_d = 1'b1;
      if (pop_ok) rd_ptr_d = rd_ptr_q + PTR_ONE;

      // Full/empty are judged on the pre-edge count.
      if (push_ok && !pop_ok)      count_d = count_q + CNT_ONE;
      else if (pop_ok && !push_ok) count_d = count_q - CNT_ONE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ack_q    <= 1'b0;
         dout_q   <= '0;
         stage_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         thr_q    <= THR_RST;
         out_q    <= '0;
         en_q     <= 1'b0;
         ien_q    <= 1'b0;
         und_q    <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         ack_q    <= ack_d;
         dout_q   <= dout_d;
         stage_q  <= stage_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         thr_q    <= thr_d;
         out_q    <= out_d;
         en_q     <= en_d;
         ien_q    <= ien_d;
         und_q    <= und_d;
         ovr_q    <= ovr_d;
      end
   end

   // Storage is not reset; only locations below count are ever read.
   always_ff @(posedge clk) begin
      if (!rst && push_ok) mem_q[wr_ptr_q] <= frame;
   end

   assign data_out = dout_q;
   assign ack      = ack_q;
   assign irq      = ien_q && (count_q <= thr_q);
   assign sample_l = out_q[39:20];
   assign sample_r = out_q[19:0];

endmodule

// File: tb/tb_audio_buf.sv
// tb_audio_buf: directed-vector bench for audio_buf (DEPTH_LOG2=4).
module tb_audio_buf;

   logic        clk = 1'b0;
   logic        rst, stb, we, next;
   logic [1:0]  addr;
   logic [31:0] data_in, data_out;
   logic        ack, irq;
   logic [19:0] sample_l, sample_r;

   int n_chk = 0;
   int n_err = 0;

   audio_buf #(.DEPTH_LOG2(4)) dut (
      .clk(clk), .rst(rst), .stb(stb), .we(we), .addr(addr),
      .data_in(data_in), .data_out(data_out), .ack(ack), .irq(irq),
      .next(next), .sample_l(sample_l), .sample_r(sample_r)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Starts #1 after a rising edge; returns #1 after the edge closing ack.
   // With nxt=1, next is pulsed on the same edge that commits the write.
   task automatic bus(input logic w, input logic [1:0] a, input logic [31:0] d,
                      input logic nxt, output logic [31:0] rd);
      bit got = 0;
      stb = 1'b1; we = w; addr = a; data_in = d;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (ack) begin got = 1; break; end
      end
      if (!got) check("ack_timeout", 32'd0, 32'd1);
      rd = data_out;
      if (nxt) next = 1'b1;
      @(posedge clk); #1;
      stb = 1'b0; next = 1'b0;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      logic [31:0] dummy;
      bus(1'b1, a, d, 1'b0, dummy);
   endtask

   task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
      logic [31:0] v;
      bus(1'b0, a, 32'd0, 1'b0, v);
      check(tag, v, exp);
   endtask

   task automatic pulse_next();
      next = 1'b1;
      @(posedge clk); #1;
      next = 1'b0;
   endtask

   task automatic push(input logic [19:0] l, input logic [19:0] r);
      wr(2'd0, 32'(l));
      wr(2'd1, 32'(r));
   endtask

   initial begin
      logic [31:0] v;
      bit got;
      rst = 1'b1; stb = 1'b0; we = 1'b0; addr = '0; data_in = '0; next = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state
      check("rst_sample_l", 32'(sample_l), 32'd0);
      check("rst_sample_r", 32'(sample_r), 32'd0);
      check("rst_irq", 32'(irq), 32'd0);
      rd_chk("rst_status", 2'd2, 32'h10);
      rd_chk("rst_thr", 2'd3, 32'd8);

      // Basic frame through the FIFO
      wr(2'd0, 32'h12345);
      rd_chk("stage_rd", 2'd0, 32'h12345);
      wr(2'd1, 32'hABCDE);
      wr(2'd2, 32'h1);
      pulse_next();
      check("basic_l", 32'(sample_l), 32'h12345);
      check("basic_r", 32'(sample_r), 32'hABCDE);
      rd_chk("basic_status", 2'd2, 32'h11);
      rd_chk("push_rd_zero", 2'd1, 32'h0);

      // Underrun on empty FIFO, then clear
      pulse_next();
      check("und_l", 32'(sample_l), 32'd0);
      check("und_r", 32'(sample_r), 32'd0);
      rd_chk("und_status", 2'd2, 32'h15);
      wr(2'd2, 32'h5);
      rd_chk("und_clr", 2'd2, 32'h11);

      // Overflow: 17 pushes with en=0, 16 survive in order
      wr(2'd2, 32'h0);
      for (int i = 1; i <= 17; i++) push(20'(i), 20'h80000 | 20'(i));
      rd_chk("full_status", 2'd2, 32'h1028);
      wr(2'd2, 32'h1);
      for (int i = 1; i <= 16; i++) begin
         pulse_next();
         check($sformatf("ovf_l%0d", i), 32'(sample_l), 32'(i));
         check($sformatf("ovf_r%0d", i), 32'(sample_r), 32'h80000 | 32'(i));
      end
      rd_chk("drain_status", 2'd2, 32'h19);
      pulse_next();
      check("f17_absent", 32'(sample_l), 32'd0);
      rd_chk("drain_und", 2'd2, 32'h1D);
      wr(2'd2, 32'hD);
      rd_chk("clr_both", 2'd2, 32'h11);

      // Threshold interrupt and simultaneous push/pop
      wr(2'd3, 32'h2);
      rd_chk("thr_rd", 2'd3, 32'h2);
      wr(2'd2, 32'h3);
      check("irq_empty", 32'(irq), 32'd1);
      for (int i = 1; i <= 3; i++) push(20'h100 + 20'(i), 20'h200 + 20'(i));
      check("irq_cnt3", 32'(irq), 32'd0);
      pulse_next();
      check("irq_cnt2", 32'(irq), 32'd1);
      check("thr_l1", 32'(sample_l), 32'h101);
      wr(2'd0, 32'h104);
      bus(1'b1, 2'd1, 32'h204, 1'b1, v);
      check("pp_l", 32'(sample_l), 32'h102);
      check("pp_r", 32'(sample_r), 32'h202);
      check("pp_irq", 32'(irq), 32'd1);
      rd_chk("pp_status", 2'd2, 32'h0203);

      // Reset between pushes at count=5, aborting an in-flight push
      wr(2'd2, 32'h0);
      for (int i = 5; i <= 7; i++) push(20'h100 + 20'(i), 20'h200 + 20'(i));
      rd_chk("cnt5_status", 2'd2, 32'h0500);
      wr(2'd0, 32'h777);
      stb = 1'b1; we = 1'b1; addr = 2'd1; data_in = 32'h888;
      got = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (ack) begin got = 1; break; end
      end
      if (!got) check("abort_ack_timeout", 32'd0, 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; stb = 1'b0;
      check("abort_ack", 32'(ack), 32'd0);
      rd_chk("rst2_status", 2'd2, 32'h10);
      rd_chk("rst2_thr", 2'd3, 32'd8);
      rd_chk("rst2_stage", 2'd0, 32'h0);
      push(20'h0BEEF, 20'h0CAFE);
      wr(2'd2, 32'h1);
      pulse_next();
      check("rst2_l", 32'(sample_l), 32'h0BEEF);
      check("rst2_r", 32'(sample_r), 32'h0CAFE);
      rd_chk("rst2_end", 2'd2, 32'h11);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
